// File: rtl/axi_pkg.sv
// Shared AXI interconnect definitions: arbitration-order constants and index-width helper.
package axi_pkg;

   localparam string LSB_LOW  = "LOW";   // highest index wins
   localparam string LSB_HIGH = "HIGH";  // index 0 wins

   // Index width for n items, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/axi_priority_encoder.sv
// Combinational priority encoder: reports whether any bit is set, the winning index and its one-hot form.
module axi_priority_encoder
   import axi_pkg::*;
#(
   parameter int    WIDTH        = 4,
   parameter string LSB_PRIORITY = LSB_LOW,
   parameter int    ENC_W        = clog2_min1(WIDTH)
) (
   input  logic [WIDTH-1:0] unencoded,
   output logic             valid,
   output logic [ENC_W-1:0] encoded,
   output logic [WIDTH-1:0] onehot
);

   localparam bit HIGH_FIRST = (LSB_PRIORITY == LSB_HIGH);

   // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      valid   = 1'b0;
      encoded = '0;
      // The last match in scan order wins, so the scan runs toward the preferred end.
      for (int i = 0; i < WIDTH; i++) begin
         if (HIGH_FIRST) begin
            if (unencoded[WIDTH-1-i]) begin
               valid   = 1'b1;
               encoded = ENC_W'(WIDTH-1-i);
            end
         end else if (unencoded[i]) begin
            valid   = 1'b1;
            encoded = ENC_W'(i);
         end
      end
   end

   assign onehot = valid ? (WIDTH'(1) << encoded) : '0;

endmodule

// File: rtl/axi_rr_arbiter.sv
// Registered round-robin / fixed-priority request arbiter with grant hold, feeding crossbar select logic.
module axi_rr_arbiter
   import axi_pkg::*;
#(
   parameter int    PORTS           = 4,
   parameter int    ARB_ROUND_ROBIN = 1,
   parameter int    ARB_BLOCK       = 1,
   parameter int    ARB_BLOCK_ACK   = 1,
   parameter string LSB_PRIORITY    = LSB_LOW
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [PORTS-1:0]               request,
   input  logic [PORTS-1:0]               acknowledge,
   output logic [PORTS-1:0]               grant,
   output logic                           grant_valid,
   output logic [clog2_min1(PORTS)-1:0]   grant_encoded
);

   localparam int ENC_W      = clog2_min1(PORTS);
   localparam bit HIGH_FIRST = (LSB_PRIORITY == LSB_HIGH);

   logic [PORTS-1:0] mask;
   logic [PORTS-1:0] masked;
   logic             req_valid, msk_valid;
   logic [ENC_W-1:0] req_enc, msk_enc;
   logic [PORTS-1:0] req_oh, msk_oh;

   logic             hold;
   logic             win_valid;
   logic [ENC_W-1:0] win_enc;
   logic [PORTS-1:0] win_oh;
   logic [PORTS-1:0] mask_next;

   assign masked = request & mask;

   axi_priority_encoder #(
      .WIDTH        (PORTS),
      .LSB_PRIORITY (LSB_PRIORITY),
      .ENC_W        (ENC_W)
   ) u_enc_request (
      .unencoded (request),
      .valid     (req_valid),
      .encoded   (req_enc),
      .onehot    (req_oh)
   );

   axi_priority_encoder #(
      .WIDTH        (PORTS),
      .LSB_PRIORITY (LSB_PRIORITY),
      .ENC_W        (ENC_W)
   ) u_enc_masked (
      .unencoded (masked),
      .valid     (msk_valid),
      .encoded   (msk_enc),
      .onehot    (msk_oh)
   );

   // Hold decision looks only at the currently granted port.
   always_comb begin
      hold = 1'b0;
      if (grant_valid && (ARB_BLOCK != 0)) begin
         if (ARB_BLOCK_ACK != 0) hold = !acknowledge[grant_encoded];
         else                    hold = request[grant_encoded];
      end
   end

   always_comb begin
      if ((ARB_ROUND_ROBIN != 0) && msk_valid) begin
         win_valid = 1'b1;
         win_enc   = msk_enc;
         win_oh    = msk_oh;
      end else begin
         win_valid = req_valid;
         win_enc   = req_enc;
         win_oh    = req_oh;
      end
      // Next mask keeps only ports that rank after the new winner.
      mask_next = '0;
      for (int i = 0; i < PORTS; i++) begin
         mask_next[i] = HIGH_FIRST ? (i > int'(win_enc)) : (i < int'(win_enc));
      end
   end

   // NOTE: state registers use nonblocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant         <= '0;
         grant_valid   <= 1'b0;
         grant_encoded <= '0;
         mask          <= '0;
      end else if (!hold) begin
         grant         <= win_oh;
         grant_valid   <= win_valid;
         grant_encoded <= win_enc;
         if (win_valid && (ARB_ROUND_ROBIN != 0)) mask <= mask_next;
      end
   end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Scoreboard bench for axi_rr_arbiter: four configurations share stimulus, a monitor checks each edge.
module tb_axi_rr_arbiter;

   typedef struct {
      int         sel;
      logic [3:0] grant;
      logic       valid;
      logic [1:0] enc;
      string      name;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] request = '0;
   logic [3:0] acknowledge = '0;

   logic [3:0] g [4];
   logic       v [4];
   logic [1:0] e [4];

   exp_t exp_q [$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   // 0: defaults (round robin, ack blocking, LOW)
   axi_rr_arbiter dut_rr (
      .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
      .grant(g[0]), .grant_valid(v[0]), .grant_encoded(e[0]));

   // 1: fixed priority, LOW
   axi_rr_arbiter #(.ARB_ROUND_ROBIN(0)) dut_fl (
      .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
      .grant(g[1]), .grant_valid(v[1]), .grant_encoded(e[1]));

   // 2: fixed priority, HIGH
   axi_rr_arbiter #(.ARB_ROUND_ROBIN(0), .LSB_PRIORITY("HIGH")) dut_fh (
      .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
      .grant(g[2]), .grant_valid(v[2]), .grant_encoded(e[2]));

   // 3: round robin, release on request drop
   axi_rr_arbiter #(.ARB_BLOCK_ACK(0)) dut_rb (
      .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
      .grant(g[3]), .grant_valid(v[3]), .grant_encoded(e[3]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic expect_grant(input int sel, input logic [3:0] gr, input string name);
      exp_t x;
      x.sel   = sel;
      x.grant = gr;
      x.valid = (gr != 4'b0);
      x.enc   = gr[3] ? 2'd3 : gr[2] ? 2'd2 : gr[1] ? 2'd1 : 2'd0;
      x.name  = name;
      exp_q.push_back(x);
   endtask

   // Drive inputs at the falling edge; the following rising edge produces the result.
   task automatic drive(input logic [3:0] req, input logic [3:0] ack);
      @(negedge clk);
      request     = req;
      acknowledge = ack;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst         = 1'b1;
      request     = '0;
      acknowledge = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: after every rising edge, drain all expectations queued for that edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         while (exp_q.size() != 0) begin
            exp_t x;
            x = exp_q.pop_front();
            check({x.name, "_grant"}, 32'(g[x.sel]), 32'(x.grant));
            check({x.name, "_valid"}, 32'(v[x.sel]), 32'(x.valid));
            check({x.name, "_enc"},   32'(e[x.sel]), 32'(x.enc));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] rr_seq [5];
      logic [3:0] ack_v;
      rr_seq = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};

      // Reset: establish grant 0100, then assert rst between edges.
      @(negedge clk);
      @(negedge clk);
      rst     = 1'b0;
      request = 4'b0100;
      expect_grant(0, 4'b0100, "pre_reset");
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("async_rst_grant", 32'(g[0]), 32'h0);
      check("async_rst_valid", 32'(v[0]), 32'h0);
      check("async_rst_enc",   32'(e[0]), 32'h0);
      @(negedge clk);
      rst     = 1'b0;
      request = 4'b0001;
      expect_grant(0, 4'b0001, "post_reset");

      // Fixed priority, both orderings.
      do_reset();
      drive(4'b0101, 4'b0000);
      expect_grant(1, 4'b0100, "fixed_low");
      expect_grant(2, 4'b0001, "fixed_high");

      // Round robin with acknowledge of the granted port each cycle.
      do_reset();
      ack_v = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         drive(4'b1111, ack_v);
         expect_grant(0, 4'b0001 << rr_seq[i], $sformatf("rr_%0d", i));
         ack_v = 4'b0001 << rr_seq[i];
      end

      // Acknowledge blocking: dropped request and foreign ack do not release.
      do_reset();
      drive(4'b1001, 4'b0000);
      expect_grant(0, 4'b1000, "ackblk_first");
      for (int i = 0; i < 5; i++) begin
         drive(4'b0001, 4'b0000);
         expect_grant(0, 4'b1000, $sformatf("ackblk_hold_%0d", i));
      end
      drive(4'b0001, 4'b0010);
      expect_grant(0, 4'b1000, "ackblk_foreign_ack");
      drive(4'b0001, 4'b1000);
      expect_grant(0, 4'b0001, "ackblk_release");

      // Request blocking: release when the granted request drops.
      do_reset();
      drive(4'b0110, 4'b0000);
      expect_grant(3, 4'b0100, "reqblk_first");
      drive(4'b0010, 4'b0000);
      expect_grant(3, 4'b0010, "reqblk_release");
      @(negedge clk);
      check("reqblk_mask", 32'(dut_rb.mask), 32'h1);
      request = 4'b0010;
      expect_grant(3, 4'b0010, "reqblk_hold");

      // Idle and empty: grant drops after ack with no requests; acks while idle ignored.
      do_reset();
      drive(4'b0010, 4'b0000);
      expect_grant(0, 4'b0010, "idle_first");
      drive(4'b0000, 4'b0010);
      expect_grant(0, 4'b0000, "idle_empty");
      drive(4'b0000, 4'b1111);
      expect_grant(0, 4'b0000, "idle_ack_ignored");
      drive(4'b0010, 4'b0000);
      expect_grant(0, 4'b0010, "idle_regrant");

      @(negedge clk);
      @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
